// File: rtl/jpeg_rle_enc_if.sv
// Bus bundle for jpeg_rle_enc: control, block-RAM read port and symbol stream.
// The encoder connects through the slave modport; the driving environment uses master.
interface jpeg_rle_enc_if #(
  parameter int unsigned ADDR_W = 9
);
  logic              start_i;
  logic              clr_pred_i;
  logic              busy_o;
  logic              done_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic              ram_en_o;
  logic [31:0]       ram_dat_i;
  logic              sym_valid_o;
  logic              sym_ready_i;
  logic [3:0]        sym_run_o;
  logic [3:0]        sym_size_o;
  logic [14:0]       sym_amp_o;
  logic              sym_dc_o;

  modport slave (
    input  start_i, clr_pred_i, ram_dat_i, sym_ready_i,
    output busy_o, done_o, ram_addr_o, ram_en_o,
           sym_valid_o, sym_run_o, sym_size_o, sym_amp_o, sym_dc_o
  );

  modport master (
    output start_i, clr_pred_i, ram_dat_i, sym_ready_i,
    input  busy_o, done_o, ram_addr_o, ram_en_o,
           sym_valid_o, sym_run_o, sym_size_o, sym_amp_o, sym_dc_o
  );
endinterface

// File: rtl/jpeg_rle_enc.sv
// JPEG entropy-prep: reads one quantised 8x8 block in zigzag order and emits
// DPCM-coded DC plus run-length coded AC (run, size, amplitude) symbols.
module jpeg_rle_enc #(
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned BLOCK_BASE = 0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  jpeg_rle_enc_if.slave bus
);
  localparam int unsigned CW = 16;
  localparam int unsigned AW = 15;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_EVAL, S_ZRL, S_SYM, S_EOB, S_DONE} state_e;

  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  // Magnitude category; callers guarantee |v| <= 32767.
  function automatic logic [3:0] size_of(input logic signed [CW-1:0] v);
    logic [AW-1:0] mag;
    mag = v[CW-1] ? AW'(-v) : v[AW-1:0];
    size_of = 4'd0;
    for (int i = 0; i < int'(AW); i++) if (mag[i]) size_of = 4'(i + 1);
  endfunction

  function automatic logic [AW-1:0] amp_of(input logic signed [CW-1:0] v, input logic [3:0] sz);
    logic [AW-1:0] t;
    logic [AW-1:0] m;
    t = v[CW-1] ? (v[AW-1:0] - AW'(1)) : v[AW-1:0];
    m = AW'((16'd1 << sz) - 16'd1);
    amp_of = t & m;
  endfunction

  state_e             state_q;
  logic [5:0]         p_q;
  logic [3:0]         run_q;
  logic [1:0]         zrl_q;
  logic signed [CW-1:0] pred_q, coef_q;
  logic               busy_q, done_q, ram_en_q;
  logic [ADDR_W-1:0]  ram_addr_q;
  logic               sym_valid_q, sym_dc_q;
  logic [3:0]         sym_run_q, sym_size_q;
  logic [AW-1:0]      sym_amp_q;

  logic [5:0]           r_cur, p_nx;
  logic [ADDR_W-1:0]    addr_0, addr_nx;
  logic signed [CW-1:0] coef_raw, coef_ac, dc_diff;
  logic signed [CW:0]   diff17;
  logic [3:0]           dc_sz, cur_sz, held_sz;
  logic [AW-1:0]        dc_amp, cur_amp, held_amp;

  // Coefficient select, DC difference with saturation, and symbol fields.
  always_comb begin
    p_nx     = p_q + 6'd1;
    r_cur    = ZZ[p_q];
    addr_0   = ADDR_W'(BLOCK_BASE) + ADDR_W'(ZZ[0][5:1]);
    addr_nx  = ADDR_W'(BLOCK_BASE) + ADDR_W'(ZZ[p_nx][5:1]);
    coef_raw = r_cur[0] ? bus.ram_dat_i[15:0] : bus.ram_dat_i[31:16];
    coef_ac  = (coef_raw == 16'sh8000) ? -16'sd32767 : coef_raw;
    diff17   = $signed({coef_raw[CW-1], coef_raw}) - $signed({pred_q[CW-1], pred_q});
    if (diff17 > 17'sd32767)       dc_diff = 16'sd32767;
    else if (diff17 < -17'sd32767) dc_diff = -16'sd32767;
    else                           dc_diff = diff17[CW-1:0];
    dc_sz    = size_of(dc_diff);
    dc_amp   = amp_of(dc_diff, dc_sz);
    cur_sz   = size_of(coef_ac);
    cur_amp  = amp_of(coef_ac, cur_sz);
    held_sz  = size_of(coef_q);
    held_amp = amp_of(coef_q, held_sz);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      p_q         <= '0;
      run_q       <= '0;
      zrl_q       <= '0;
      pred_q      <= '0;
      coef_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_addr_q  <= '0;
      sym_valid_q <= 1'b0;
      sym_dc_q    <= 1'b0;
      sym_run_q   <= '0;
      sym_size_q  <= '0;
      sym_amp_q   <= '0;
    end else begin
      done_q   <= 1'b0;
      ram_en_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.clr_pred_i) pred_q <= '0;
          if (bus.start_i) begin
            busy_q     <= 1'b1;
            p_q        <= '0;
            run_q      <= '0;
            zrl_q      <= '0;
            ram_en_q   <= 1'b1;
            ram_addr_q <= addr_0;
            state_q    <= S_RD;
          end
        end
        S_RD: state_q <= S_EVAL;
        S_EVAL: begin
          coef_q <= coef_ac;
          if (p_q == 6'd0) begin
            pred_q      <= coef_raw;
            sym_run_q   <= '0;
            sym_size_q  <= dc_sz;
            sym_amp_q   <= dc_amp;
            sym_dc_q    <= 1'b1;
            sym_valid_q <= 1'b1;
            state_q     <= S_SYM;
          end else if (coef_raw == '0) begin
            // Each 16th consecutive zero becomes a pending ZRL.
            if (run_q == 4'd15) begin
              run_q <= '0;
              zrl_q <= zrl_q + 2'd1;
            end else begin
              run_q <= run_q + 4'd1;
            end
            if (p_q == 6'd63) begin
              zrl_q       <= '0;
              sym_run_q   <= '0;
              sym_size_q  <= '0;
              sym_amp_q   <= '0;
              sym_dc_q    <= 1'b0;
              sym_valid_q <= 1'b1;
              state_q     <= S_EOB;
            end else begin
              p_q        <= p_nx;
              ram_en_q   <= 1'b1;
              ram_addr_q <= addr_nx;
              state_q    <= S_RD;
            end
          end else if (zrl_q != 2'd0) begin
            sym_run_q   <= 4'd15;
            sym_size_q  <= '0;
            sym_amp_q   <= '0;
            sym_dc_q    <= 1'b0;
            sym_valid_q <= 1'b1;
            state_q     <= S_ZRL;
          end else begin
            sym_run_q   <= run_q;
            sym_size_q  <= cur_sz;
            sym_amp_q   <= cur_amp;
            sym_dc_q    <= 1'b0;
            sym_valid_q <= 1'b1;
            state_q     <= S_SYM;
          end
        end
        S_ZRL: begin
          if (bus.sym_ready_i) begin
            zrl_q <= zrl_q - 2'd1;
            if (zrl_q == 2'd1) begin
              sym_run_q  <= run_q;
              sym_size_q <= held_sz;
              sym_amp_q  <= held_amp;
              state_q    <= S_SYM;
            end
          end
        end
        S_SYM: begin
          if (bus.sym_ready_i) begin
            sym_valid_q <= 1'b0;
            sym_dc_q    <= 1'b0;
            sym_run_q   <= '0;
            sym_size_q  <= '0;
            sym_amp_q   <= '0;
            run_q       <= '0;
            if (p_q == 6'd63) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              p_q        <= p_nx;
              ram_en_q   <= 1'b1;
              ram_addr_q <= addr_nx;
              state_q    <= S_RD;
            end
          end
        end
        S_EOB: begin
          if (bus.sym_ready_i) begin
            sym_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.ram_addr_o  = ram_addr_q;
  assign bus.ram_en_o    = ram_en_q;
  assign bus.sym_valid_o = sym_valid_q;
  assign bus.sym_run_o   = sym_run_q;
  assign bus.sym_size_o  = sym_size_q;
  assign bus.sym_amp_o   = sym_amp_q;
  assign bus.sym_dc_o    = sym_dc_q;
endmodule

// File: tb/tb_jpeg_rle_enc.sv
// Directed bench for jpeg_rle_enc: block RAM model, symbol monitor and one
// task per scenario with hand-computed symbol sequences.
module tb_jpeg_rle_enc;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned BASE   = 0;

  logic clk    = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  jpeg_rle_enc_if #(.ADDR_W(ADDR_W)) bus ();
  jpeg_rle_enc #(.ADDR_W(ADDR_W), .BLOCK_BASE(BASE)) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  logic [31:0] mem [512];
  logic [31:0] rdat = '0;
  always @(posedge clk) if (bus.ram_en_o) rdat <= mem[bus.ram_addr_o];
  assign bus.ram_dat_i = rdat;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  logic rand_rdy = 1'b0;
  logic signed [15:0] blk [64];
  logic [23:0] got [$];
  logic [ADDR_W-1:0] rd_log [$];
  logic prev_stall = 1'b0;
  logic [23:0] prev_sym = '0;
  logic [23:0] cur_sym;

  function automatic logic [23:0] S(input logic dc, input int run, input int sz, input int amp);
    return {dc, 4'(run), 4'(sz), 15'(amp)};
  endfunction

  // Ready driver: always-ready or random backpressure.
  initial begin
    bus.sym_ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.sym_ready_i = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: handshakes, reads, done pulses and hold-while-stalled.
  always @(negedge clk) begin
    cur_sym = {bus.sym_dc_o, bus.sym_run_o, bus.sym_size_o, bus.sym_amp_o};
    if (bus.done_o) done_cnt++;
    if (bus.ram_en_o) rd_log.push_back(bus.ram_addr_o);
    if (rst_ni && prev_stall) begin
      n_checks++;
      if (bus.sym_valid_o !== 1'b1 || cur_sym !== prev_sym) begin
        n_fail++;
        $display("FAIL stall_hold got valid=%b sym=%h exp valid=1 sym=%h", bus.sym_valid_o, cur_sym, prev_sym);
      end
    end
    if (bus.sym_valid_o && bus.sym_ready_i) got.push_back(cur_sym);
    prev_stall = rst_ni && bus.sym_valid_o && !bus.sym_ready_i;
    prev_sym   = cur_sym;
  end

  task automatic clear_blk();
    for (int i = 0; i < 64; i++) blk[i] = '0;
  endtask

  task automatic load_blk();
    for (int k = 0; k < 32; k++) mem[BASE + k] = {blk[2*k], blk[2*k+1]};
  endtask

  task automatic run_block(input logic clr, output logic seen);
    int d0;
    d0 = done_cnt;
    got.delete();
    rd_log.delete();
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.clr_pred_i = clr;
    @(posedge clk); #1;
    bus.start_i = 1'b0; bus.clr_pred_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (done_cnt != d0) seen = 1'b1;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy_o); end
    n_checks++; if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", bus.done_o); end
    n_checks++; if (bus.sym_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus.sym_valid_o); end
    n_checks++; if (bus.ram_en_o !== 1'b0) begin n_fail++; $display("FAIL reset_ram_en got=%b exp=0", bus.ram_en_o); end
    n_checks++; if (bus.ram_addr_o !== '0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", bus.ram_addr_o); end
    n_checks++; if (cur_sym !== 24'h0) begin n_fail++; $display("FAIL reset_sym got=%h exp=0", cur_sym); end
  endtask

  task automatic test_dc_first();
    logic [23:0] exp [$];
    logic seen;
    int d0;
    clear_blk(); blk[0] = 16'sd5; load_blk();
    d0 = done_cnt;
    run_block(1'b1, seen);
    exp = '{S(1, 0, 3, 5), S(0, 0, 0, 0)};
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL dc_first_done_seen got=%b exp=1", seen); end
    n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL dc_first_done_pulses got=%0d exp=1", done_cnt - d0); end
    n_checks++; if (got.size() != exp.size()) begin n_fail++; $display("FAIL dc_first_count got=%0d exp=%0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      n_checks++;
      if (i >= got.size() || got[i] !== exp[i]) begin n_fail++; $display("FAIL dc_first_sym[%0d] got=%h exp=%h", i, got[i], exp[i]); end
    end
    n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL dc_first_busy_after got=%b exp=0", bus.busy_o); end
  endtask

  task automatic test_dc_pred();
    logic [23:0] exp [$];
    logic seen;
    run_block(1'b0, seen);
    exp = '{S(1, 0, 0, 0), S(0, 0, 0, 0)};
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL dc_same_done got=%b exp=1", seen); end
    n_checks++; if (got.size() != exp.size()) begin n_fail++; $display("FAIL dc_same_count got=%0d exp=%0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      n_checks++;
      if (i >= got.size() || got[i] !== exp[i]) begin n_fail++; $display("FAIL dc_same_sym[%0d] got=%h exp=%h", i, got[i], exp[i]); end
    end
    clear_blk(); blk[0] = 16'sd2; load_blk();
    run_block(1'b0, seen);
    exp = '{S(1, 0, 2, 0), S(0, 0, 0, 0)};
    n_checks++; if (got.size() != exp.size()) begin n_fail++; $display("FAIL dc_neg_count got=%0d exp=%0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      n_checks++;
      if (i >= got.size() || got[i] !== exp[i]) begin n_fail++; $display("FAIL dc_neg_sym[%0d] got=%h exp=%h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_zigzag();
    logic [23:0] exp [$];
    logic seen;
    clear_blk(); blk[1] = -16'sd1; blk[8] = 16'sd3; load_blk();
    run_block(1'b1, seen);
    exp = '{S(1, 0, 0, 0), S(0, 0, 1, 0), S(0, 0, 2, 3), S(0, 0, 0, 0)};
    n_checks++; if (rd_log.size() != 64) begin n_fail++; $display("FAIL zz_read_count got=%0d exp=64", rd_log.size()); end
    n_checks++; if (rd_log.size() < 3 || rd_log[1] !== 9'd0) begin n_fail++; $display("FAIL zz_addr_p1 got=%0d exp=0", rd_log[1]); end
    n_checks++; if (rd_log.size() < 3 || rd_log[2] !== 9'd4) begin n_fail++; $display("FAIL zz_addr_p2 got=%0d exp=4", rd_log[2]); end
    n_checks++; if (got.size() != exp.size()) begin n_fail++; $display("FAIL zz_count got=%0d exp=%0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      n_checks++;
      if (i >= got.size() || got[i] !== exp[i]) begin n_fail++; $display("FAIL zz_sym[%0d] got=%h exp=%h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_zrl_last();
    logic [23:0] exp [$];
    logic seen;
    clear_blk(); blk[63] = 16'sd1; load_blk();
    run_block(1'b1, seen);
    exp = '{S(1, 0, 0, 0), S(0, 15, 0, 0), S(0, 15, 0, 0), S(0, 15, 0, 0), S(0, 14, 1, 1)};
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL zrl_last_done got=%b exp=1", seen); end
    n_checks++; if (got.size() != exp.size()) begin n_fail++; $display("FAIL zrl_last_count got=%0d exp=%0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      n_checks++;
      if (i >= got.size() || got[i] !== exp[i]) begin n_fail++; $display("FAIL zrl_last_sym[%0d] got=%h exp=%h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_zrl_mid(input logic stall);
    logic [23:0] exp [$];
    logic seen;
    rand_rdy = stall;
    clear_blk(); blk[29] = 16'sd7; load_blk();
    run_block(1'b1, seen);
    rand_rdy = 1'b0;
    exp = '{S(1, 0, 0, 0), S(0, 15, 0, 0), S(0, 15, 0, 0), S(0, 7, 3, 7), S(0, 0, 0, 0)};
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL zrl_mid_done stall=%b got=%b exp=1", stall, seen); end
    n_checks++; if (got.size() != exp.size()) begin n_fail++; $display("FAIL zrl_mid_count stall=%b got=%0d exp=%0d", stall, got.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      n_checks++;
      if (i >= got.size() || got[i] !== exp[i]) begin n_fail++; $display("FAIL zrl_mid_sym[%0d] stall=%b got=%h exp=%h", i, stall, got[i], exp[i]); end
    end
  endtask

  task automatic test_saturation();
    logic [23:0] exp [$];
    logic seen;
    clear_blk(); blk[0] = 16'sh8000; blk[1] = -16'sd300; load_blk();
    run_block(1'b1, seen);
    exp = '{S(1, 0, 15, 0), S(0, 0, 9, 211), S(0, 0, 0, 0)};
    n_checks++; if (got.size() != exp.size()) begin n_fail++; $display("FAIL sat_lo_count got=%0d exp=%0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      n_checks++;
      if (i >= got.size() || got[i] !== exp[i]) begin n_fail++; $display("FAIL sat_lo_sym[%0d] got=%h exp=%h", i, got[i], exp[i]); end
    end
    clear_blk(); blk[0] = 16'sd32767; load_blk();
    run_block(1'b0, seen);
    exp = '{S(1, 0, 15, 32767), S(0, 0, 0, 0)};
    n_checks++; if (got.size() != exp.size()) begin n_fail++; $display("FAIL sat_hi_count got=%0d exp=%0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      n_checks++;
      if (i >= got.size() || got[i] !== exp[i]) begin n_fail++; $display("FAIL sat_hi_sym[%0d] got=%h exp=%h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    int d0;
    clear_blk(); blk[0] = 16'sd9; blk[63] = 16'sd1; load_blk();
    d0 = done_cnt;
    rand_rdy = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.clr_pred_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0; bus.clr_pred_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (bus.sym_valid_o && bus.sym_run_o == 4'd15) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL rst_mid_reach_zrl got=%b exp=1", seen); end
    @(posedge clk); #1 rst_ni = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    rand_rdy = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got=%b exp=0", bus.busy_o); end
    n_checks++; if (bus.sym_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid got=%b exp=0", bus.sym_valid_o); end
    n_checks++; if (cur_sym !== 24'h0) begin n_fail++; $display("FAIL rst_mid_sym got=%h exp=0", cur_sym); end
    repeat (100) @(negedge clk);
    n_checks++; if (done_cnt != d0) begin n_fail++; $display("FAIL rst_mid_no_done got=%0d exp=0", done_cnt - d0); end
    n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_idle got=%b exp=0", bus.busy_o); end
    clear_blk(); blk[0] = 16'sd5; load_blk();
    run_block(1'b0, seen);
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL rst_mid_next_done got=%b exp=1", seen); end
    n_checks++; if (got.size() < 1 || got[0] !== S(1, 0, 3, 5)) begin n_fail++; $display("FAIL rst_mid_pred got=%h exp=%h", got[0], S(1, 0, 3, 5)); end
  endtask

  initial begin
    bus.start_i    = 1'b0;
    bus.clr_pred_i = 1'b0;
    for (int i = 0; i < 512; i++) mem[i] = '0;
    test_reset();
    test_dc_first();
    test_dc_pred();
    test_zigzag();
    test_zrl_last();
    test_zrl_mid(1'b0);
    test_saturation();
    test_zrl_mid(1'b1);
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
